distribution_op_scheduler: RTL and testbench
============================================

# distribution_op_scheduler

Sequences the multi-cycle distribution arithmetic unit in the RV32I pipeline and arbitrates its completion write into the distribution register file. Accepts one distribution op at a time from ID and counts its fixed latency. It then competes with the MEM-stage distribution write for the single D-register write port. It drives the ID stall whenever a younger instruction reads or writes the in-flight destination, covering the hazard the combinational distribution forwarding path cannot resolve.

## Interface
Parameters:
- LATENCY, 4, cycles from DU_start to result valid; legal range 1..15.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- ID_dOpValid  in  1  ID holds a multi-cycle distribution op.
- ID_dOpDest  in  5  destination D register of that op.
- ID_dSrcAddr  in  5  D register read by the instruction in ID (any type).
- ID_dSrcUsed  in  1  ID instruction reads ID_dSrcAddr.
- ID_dWrite  in  1  ID instruction writes a D register through the normal pipeline.
- ID_dWriteAddr  in  5  that destination.
- MEM_DRegWrite  in  1  MEM stage owns the D write port this cycle; it has priority.
- DU_start  out  1  one-cycle start pulse to the distribution unit.
- DU_destAddr  out  5  registered destination of the in-flight op.
- WB_DRegWrite  out  1  scheduler writes the DU result this cycle.
- WB_destAddr  out  5  address for that write (equals DU_destAddr).
- ID_dStall  out  1  freeze IF/ID, bubble EX.
- busy  out  1  state != IDLE.

## Operation
- States: IDLE, BUSY, WRITE. 4-bit down-counter cnt.
- IDLE: accept = ID_dOpValid. DU_start = accept (combinational). On accept, latch ID_dOpDest into DU_destAddr, cnt <= LATENCY-1, go BUSY.
- Ops with ID_dOpDest = 0 are accepted and timed, but WB_DRegWrite is never asserted for them. They do not cause RAW/WAW stalls.
- BUSY: cnt decrements each cycle. At cnt = 0, go WRITE on the next edge. BUSY lasts exactly LATENCY cycles.
- WRITE:
  - If MEM_DRegWrite = 0: WB_DRegWrite = 1 (dest != 0) for this cycle, then go IDLE.
  - If MEM_DRegWrite = 1: hold WRITE with WB_DRegWrite = 0 and retry next cycle. There is no starvation bound beyond MEM behaviour.
- ID_dStall is asserted (combinationally) when any of the following holds:
  - ID_dOpValid and state != IDLE (structural).
  - state != IDLE, DU_destAddr != 0, ID_dSrcUsed, and ID_dSrcAddr == DU_destAddr (RAW).
  - state != IDLE, DU_destAddr != 0, ID_dWrite, and ID_dWriteAddr == DU_destAddr (WAW).
- RAW stall includes the WRITE cycle itself: there is no bypass from WB. It releases the cycle after WB_DRegWrite.
- No new op is accepted in the WRITE cycle. The earliest back-to-back issue is the cycle after the write.
- A structural stall overrides acceptance: DU_start never pulses while state != IDLE.

## Timing
- Reset (async, immediate): state IDLE, cnt 0, DU_destAddr 0. Outputs: DU_start 0, WB_DRegWrite 0, WB_destAddr 0, busy 0. ID_dStall is 0 unless ID inputs request it against IDLE state, which never stalls.
- Reset mid-op aborts silently: no write-back occurs and stalls drop in the same cycle.
- Accept at cycle t: BUSY in cycles t+1..t+LATENCY, WRITE at t+LATENCY+1. With no port conflict, WB_DRegWrite is asserted at t+LATENCY+1 and next accept is possible at t+LATENCY+2.
- Each MEM_DRegWrite cycle during WRITE adds one cycle of delay.
- Simultaneous ID_dOpValid and a RAW/WAW match in IDLE: no stall. The pending state is empty.

## Test plan
- LATENCY=4: issue op dest=5 at cycle 10 -> DU_start=1 at 10, busy 11..15, WB_DRegWrite=1 with WB_destAddr=5 at 15, busy=0 at 16.
- In-flight dest=5, ID reads x5 from cycle 11 -> ID_dStall=1 cycles 11..15, 0 at 16; reading x6 -> never stalls.
- MEM_DRegWrite=1 on cycles 15 and 16 -> WB_DRegWrite held low, asserted at 17, ID_dStall on x5 read released at 18.
- Second op presented at cycle 12 -> ID_dStall=1 until 15, DU_start at 16, write at 21.
- Dest=0 op -> full LATENCY timing, WB_DRegWrite never asserted, no stall on x0 read/write.
- Assert rst at cycle 13 mid-BUSY -> all outputs 0 immediately, no write-back, new op accepted at first post-reset cycle.

Source files
------------

// File: rtl/distribution_op_scheduler.sv
// Sequences the multi-cycle distribution unit and arbitrates its result
// write into the D register file against the MEM-stage write.
//
// Ports:
//   clk, rst        : clock, async active-high reset
//   ID_dOpValid     : ID holds a multi-cycle distribution op
//   ID_dOpDest      : destination D register of that op
//   ID_dSrcAddr     : D register read by the ID instruction
//   ID_dSrcUsed     : ID instruction reads ID_dSrcAddr
//   ID_dWrite       : ID instruction writes a D register normally
//   ID_dWriteAddr   : that destination
//   MEM_DRegWrite   : MEM owns the D write port (has priority)
//   DU_start        : one-cycle start pulse to the distribution unit
//   DU_destAddr     : registered destination of the in-flight op
//   WB_DRegWrite    : scheduler writes the DU result this cycle
//   WB_destAddr     : address of that write
//   ID_dStall       : freeze IF/ID, bubble EX
//   busy            : an op is in flight
module distribution_op_scheduler #(
  parameter int unsigned LATENCY = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ID_dOpValid,
  input  logic [4:0] ID_dOpDest,
  input  logic [4:0] ID_dSrcAddr,
  input  logic       ID_dSrcUsed,
  input  logic       ID_dWrite,
  input  logic [4:0] ID_dWriteAddr,
  input  logic       MEM_DRegWrite,
  output logic       DU_start,
  output logic [4:0] DU_destAddr,
  output logic       WB_DRegWrite,
  output logic [4:0] WB_destAddr,
  output logic       ID_dStall,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_WRITE
  } state_t;

  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_nxt;
  logic [4:0] r_dest;
  logic [4:0] w_dest_nxt;

  logic w_active;
  logic w_dest_live;
  logic w_struct;
  logic w_raw;
  logic w_waw;
  logic w_start;
  logic w_wb;

  assign w_active    = (r_state != S_IDLE);
  assign w_dest_live = (r_dest != 5'd0);

  // x0 is never written, so it can never be a RAW/WAW hazard.
  assign w_struct = w_active & ID_dOpValid;
  assign w_raw    = w_active & w_dest_live & ID_dSrcUsed
                  & (ID_dSrcAddr == r_dest);
  assign w_waw    = w_active & w_dest_live & ID_dWrite
                  & (ID_dWriteAddr == r_dest);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_dest  <= 5'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_dest  <= w_dest_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_dest_nxt  = r_dest;
    w_start     = 1'b0;
    w_wb        = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (ID_dOpValid) begin
          w_start     = 1'b1;
          w_dest_nxt  = ID_dOpDest;
          w_cnt_nxt   = LAT_M1;
          w_state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = S_WRITE;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      S_WRITE: begin
        // MEM owns the port: hold and retry next cycle.
        if (!MEM_DRegWrite) begin
          w_wb        = w_dest_live;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Gate the combinational start so reset silences it immediately.
  assign DU_start     = w_start & ~rst;
  assign DU_destAddr  = r_dest;
  assign WB_DRegWrite = w_wb;
  assign WB_destAddr  = r_dest;
  assign ID_dStall    = w_struct | w_raw | w_waw;
  assign busy         = w_active;

endmodule

// File: tb/tb_distribution_op_scheduler.sv
// Randomized self-checking bench for distribution_op_scheduler.
// Reference model tracks in-flight op age in cycles since acceptance.
module tb_distribution_op_scheduler;

  localparam int L = 4;

  logic       clk;
  logic       rst;
  logic       ID_dOpValid;
  logic [4:0] ID_dOpDest;
  logic [4:0] ID_dSrcAddr;
  logic       ID_dSrcUsed;
  logic       ID_dWrite;
  logic [4:0] ID_dWriteAddr;
  logic       MEM_DRegWrite;
  logic       DU_start;
  logic [4:0] DU_destAddr;
  logic       WB_DRegWrite;
  logic [4:0] WB_destAddr;
  logic       ID_dStall;
  logic       busy;

  int n_cmp;
  int n_bad;

  // Model: op in flight, cycles since accept, its destination.
  bit       m_act;
  int       m_age;
  logic [4:0] m_dest;
  int       n_wb;

  distribution_op_scheduler #(.LATENCY(L)) dut (
    .clk(clk),
    .rst(rst),
    .ID_dOpValid(ID_dOpValid),
    .ID_dOpDest(ID_dOpDest),
    .ID_dSrcAddr(ID_dSrcAddr),
    .ID_dSrcUsed(ID_dSrcUsed),
    .ID_dWrite(ID_dWrite),
    .ID_dWriteAddr(ID_dWriteAddr),
    .MEM_DRegWrite(MEM_DRegWrite),
    .DU_start(DU_start),
    .DU_destAddr(DU_destAddr),
    .WB_DRegWrite(WB_DRegWrite),
    .WB_destAddr(WB_destAddr),
    .ID_dStall(ID_dStall),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  task automatic drive(input logic ov, input logic [4:0] od,
                       input logic [4:0] sa, input logic su,
                       input logic w, input logic [4:0] wa,
                       input logic mem);
    ID_dOpValid   = ov;
    ID_dOpDest    = od;
    ID_dSrcAddr   = sa;
    ID_dSrcUsed   = su;
    ID_dWrite     = w;
    ID_dWriteAddr = wa;
    MEM_DRegWrite = mem;
  endtask

  // One cycle: drive at negedge, check settled outputs, advance model.
  task automatic step(input logic ov, input logic [4:0] od,
                      input logic [4:0] sa, input logic su,
                      input logic w, input logic [4:0] wa,
                      input logic mem);
    bit e_start, e_wb, e_stall, hz;
    @(negedge clk);
    drive(ov, od, sa, su, w, wa, mem);
    #1;
    e_start = !m_act && ov;
    e_wb    = m_act && (m_age > L) && !mem && (m_dest != 0);
    hz      = (m_dest != 0) &&
              ((su && sa == m_dest) || (w && wa == m_dest));
    e_stall = m_act && (ov || hz);
    chk("start", 32'(DU_start), 32'(e_start));
    chk("busy", 32'(busy), 32'(m_act));
    chk("wb", 32'(WB_DRegWrite), 32'(e_wb));
    chk("stall", 32'(ID_dStall), 32'(e_stall));
    chk("dest", 32'(DU_destAddr), 32'(m_dest));
    chk("wbaddr", 32'(WB_destAddr), 32'(m_dest));
    if (e_wb) n_wb++;
    @(posedge clk);
    if (!m_act) begin
      if (ov) begin
        m_act  = 1;
        m_age  = 1;
        m_dest = od;
      end
    end else if (m_age > L && !mem) begin
      m_act = 0;
    end else begin
      m_age++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  // Async reset in mid-cycle, with ID requesting a hazard on the old dest.
  task automatic pulse_reset();
    logic [4:0] d;
    @(negedge clk);
    d = m_dest;
    drive(1, 5'd5, d, 1, 1, d, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_start", 32'(DU_start), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_wb", 32'(WB_DRegWrite), 0);
    chk("rst_stall", 32'(ID_dStall), 0);
    chk("rst_dest", 32'(DU_destAddr), 0);
    m_act  = 0;
    m_age  = 0;
    m_dest = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    n_cmp  = 0;
    n_bad  = 0;
    n_wb   = 0;
    m_act  = 0;
    m_age  = 0;
    m_dest = 0;
    drive(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    #1;
    chk("por_busy", 32'(busy), 0);
    chk("por_wb", 32'(WB_DRegWrite), 0);
    chk("por_dest", 32'(WB_destAddr), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);

    // Basic op dest=5 while ID reads x5, then a read of x6.
    step(1, 5, 0, 0, 0, 0, 0);
    for (int i = 0; i < L + 2; i++) step(0, 0, 5, 1, 0, 0, 0);
    step(1, 5, 6, 1, 0, 0, 0);
    for (int i = 0; i < L + 2; i++) step(0, 0, 6, 1, 0, 0, 0);

    // MEM owns the port for two WRITE cycles.
    step(1, 5, 0, 0, 0, 0, 0);
    for (int i = 0; i < L; i++) step(0, 0, 5, 1, 0, 0, 0);
    step(0, 0, 5, 1, 0, 0, 1);
    step(0, 0, 5, 1, 0, 0, 1);
    step(0, 0, 5, 1, 0, 0, 0);
    step(0, 0, 5, 1, 0, 0, 0);

    // Second op held by structural stall until the cycle after write.
    step(1, 7, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < L + 1; i++) step(1, 9, 0, 0, 0, 0, 0);
    idle(L + 2);

    // Dest=0 op: timed normally, never writes, no x0 hazards.
    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < L + 2; i++) step(0, 0, 0, 1, 1, 0, 0);

    // WAW on the in-flight destination.
    step(1, 3, 0, 0, 0, 0, 0);
    for (int i = 0; i < L + 2; i++) step(0, 0, 0, 0, 1, 3, 0);

    // Reset mid-BUSY, then accept on the first post-reset cycle.
    step(1, 5, 0, 0, 0, 0, 0);
    step(0, 0, 5, 1, 0, 0, 0);
    step(0, 0, 5, 1, 0, 0, 0);
    pulse_reset();
    step(1, 6, 0, 0, 0, 0, 0);
    idle(L + 2);

    if (n_wb < 3) begin
      n_bad++;
      $display("FAIL wb_count got=%0d exp>=3", n_wb);
    end

    for (int i = 0; i < 3000; i++) begin
      logic [4:0] od, sa, wa;
      od = 5'($urandom_range(0, 7));
      sa = 5'($urandom_range(0, 7));
      wa = 5'($urandom_range(0, 7));
      if ($urandom_range(0, 299) == 0) begin
        pulse_reset();
      end else begin
        step(logic'($urandom_range(0, 3) == 0), od,
             sa, logic'($urandom_range(0, 1)),
             logic'($urandom_range(0, 1)), wa,
             logic'($urandom_range(0, 2) == 0));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
